// File: rtl/prog_sequencer.sv
// Run-control sequencer: owns the program counter and the IDLE/RUN/HALT state.
// Optional executed-cycle counter is enabled by defining SEQ_CYCLE_CNT_EN.
module prog_sequencer #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [8:0]       Instruction,
  input  logic             Branch,
  input  logic             BranchCond,
  input  logic             CondFlag,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             ExecEn,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic              busy_reg, done_reg;
  logic              halt;
  logic              take_branch;

  assign halt        = (Instruction == 9'h1FF);
  assign take_branch = Branch && (!BranchCond || CondFlag);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      IDLE, HALT: begin
        if (Start) begin
          state_next = RUN;
          pc_next    = START_ADDR;
        end
      end
      RUN: begin
        // The halt word also decodes as R-type, so it must win over Branch.
        if (halt) begin
          state_next = HALT;
        end else if (take_branch) begin
          pc_next = Target;
        end else begin
          pc_next = pc_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      pc_reg    <= START_ADDR;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      busy_reg  <= (state_next == RUN);
      done_reg  <= (state_next == HALT);
    end
  end

  // A pending synchronous reset squashes any write in the cycle it is applied.
  assign ExecEn  = (state_reg == RUN) && !halt && !Reset;
  assign ProgCtr = pc_reg;
  assign Busy    = busy_reg;
  assign Done    = done_reg;

`ifdef SEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic             launch;

  assign launch = (state_next == RUN) && (state_reg != RUN);

  always_ff @(posedge Clk) begin
    if (Reset || launch) begin
      cnt_reg <= '0;
    end else if ((state_reg == RUN) && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign CycleCount = cnt_reg;
`else
  assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed scenarios followed by randomized run control,
// all compared against a cycle-level behavioural model of the run state and PC.
module tb_prog_sequencer;
  localparam int PC_W  = 10;
  localparam int CNT_W = 16;
  localparam int DEPTH = 1 << PC_W;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic [8:0]       Instruction;
  logic             Branch = 1'b0;
  logic             BranchCond = 1'b0;
  logic             CondFlag = 1'b0;
  logic [PC_W-1:0]  Target = '0;
  logic [PC_W-1:0]  ProgCtr;
  logic             ExecEn;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] CycleCount;

  logic [8:0] rom [DEPTH];

  // Model: 0 = idle, 1 = running, 2 = halted
  int m_state = 0;
  int m_pc    = 0;
  int m_cnt   = 0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 Clk = ~Clk;

  assign Instruction = rom[ProgCtr];

  prog_sequencer #(
    .PC_W      (PC_W),
    .START_ADDR('0),
    .CNT_W     (CNT_W)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Instruction(Instruction),
    .Branch     (Branch),
    .BranchCond (BranchCond),
    .CondFlag   (CondFlag),
    .Target     (Target),
    .ProgCtr    (ProgCtr),
    .ExecEn     (ExecEn),
    .Busy       (Busy),
    .Done       (Done),
    .CycleCount (CycleCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int exp_cnt();
`ifdef SEQ_CYCLE_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  // Drive one cycle's inputs, compare the pre-edge outputs with the model, then advance it.
  task automatic cycle(input logic rst, input logic st, input logic br, input logic bc,
                       input logic cf, input logic [PC_W-1:0] tgt);
    @(negedge Clk);
    Reset = rst; Start = st; Branch = br; BranchCond = bc; CondFlag = cf; Target = tgt;
    #1;
    check("pc",     ProgCtr,    m_pc);
    check("busy",   Busy,       (m_state == 1) ? 1 : 0);
    check("done",   Done,       (m_state == 2) ? 1 : 0);
    check("count",  CycleCount, exp_cnt());
    check("execen", ExecEn,     (m_state == 1 && rom[m_pc] != 9'h1FF && !rst) ? 1 : 0);
    @(posedge Clk);
    if (rst) begin
      m_state = 0; m_pc = 0; m_cnt = 0;
    end else if (m_state == 1) begin
      m_cnt = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
      if (rom[m_pc] == 9'h1FF) m_state = 2;
      else if (br && (!bc || cf)) m_pc = int'(tgt);
      else m_pc = (m_pc + 1) % DEPTH;
    end else if (st) begin
      m_state = 1; m_pc = 0; m_cnt = 0;
    end
    #1;
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, '0);
  endtask

  task automatic launch();
    cycle(1, 0, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, 0, '0);
  endtask

  task automatic fill_plain();
    for (int i = 0; i < DEPTH; i++) rom[i] = 9'h000;
  endtask

  initial begin
    fill_plain();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_pc",   ProgCtr, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_cnt",  CycleCount, 0);
    check("rst_exec", ExecEn, 0);

    // Straight line to halt, then restart from HALT
    rom[5] = 9'h1FF;
    launch();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 0, '0);
      if (i < 5) check("t1_pc", ProgCtr, i + 1);
    end
    check("t1_done", Done, 1);
    check("t1_pc_hold", ProgCtr, 5);
`ifdef SEQ_CYCLE_CNT_EN
    check("t1_count", CycleCount, 6);
`endif
    cycle(0, 1, 0, 0, 0, '0);
    check("t6_pc", ProgCtr, 0);
    check("t6_done", Done, 0);
    check("t6_busy", Busy, 1);
    cycle(0, 0, 0, 0, 0, '0);
`ifdef SEQ_CYCLE_CNT_EN
    check("t6_count", CycleCount, 1);
`endif
    $display("directed: straight line + restart done (%0d checks)", chk_cnt);

    // Unconditional branch
    fill_plain();
    launch();
    plain(3);
    cycle(0, 0, 1, 0, 0, 10'd40);
    check("t2_pc", ProgCtr, 40);
    $display("directed: unconditional branch done (%0d checks)", chk_cnt);

    // Conditional branch, not taken then taken
    launch();
    plain(7);
    cycle(0, 0, 1, 1, 0, 10'd2);
    check("t3_not_taken", ProgCtr, 8);
    launch();
    plain(7);
    cycle(0, 0, 1, 1, 1, 10'd2);
    check("t3_taken", ProgCtr, 2);
    $display("directed: conditional branch done (%0d checks)", chk_cnt);

    // Top address wraps to 0
    launch();
    cycle(0, 0, 1, 0, 0, 10'd1022);
    plain(1);
    check("t4_top", ProgCtr, 1023);
    plain(1);
    check("t4_wrap", ProgCtr, 0);
    $display("directed: wrap done (%0d checks)", chk_cnt);

    // Start ignored in RUN; reset mid-run
    launch();
    plain(4);
    cycle(0, 1, 0, 0, 0, '0);
    check("t5_start_ign", ProgCtr, 5);
    plain(4);
    cycle(1, 1, 1, 0, 0, 10'd77);
    check("t5_busy", Busy, 0);
    check("t5_pc", ProgCtr, 0);
    check("t5_exec", ExecEn, 0);
    plain(1);
    check("t5_idle_pc", ProgCtr, 0);
    check("t5_idle_busy", Busy, 0);
    $display("directed: reset mid-run done (%0d checks)", chk_cnt);

    // Randomized program and control inputs
    for (int i = 0; i < DEPTH; i++)
      rom[i] = ($urandom_range(19) == 0) ? 9'h1FF : 9'($urandom);
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(99) == 0), ($urandom_range(5) == 0), ($urandom_range(3) == 0),
            1'($urandom), 1'($urandom), 10'($urandom));
    end
    $display("random: 4000 cycles done (%0d checks)", chk_cnt);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
